hamming_rx_ctrl: RTL and testbench

Receive-side controller for the Hamming(7,4) link. Accepts a serial bit stream, assembles 7-bit codewords, and sequences them through an internal instance of the team's hamming_7_4 combinational decoder. Pairs each two decoded nibbles into a byte, presents the byte on a valid/ready output, and keeps a saturating count of corrected codewords. Sits between the serial line sampler and the byte-wide consumer.

---
 rtl/hamming_rx_ctrl.sv | 175 +++++++++++++++++
 tb/tb_hamming_rx_ctrl.sv | 382 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hamming_rx_ctrl.sv
// Receive-side Hamming(7,4) controller: serial bits in, codewords decoded and
// paired into bytes on a valid/ready output, with a saturating corrected-error count.

module hamming_7_4 (
    input  logic [6:0] code,
    output logic [3:0] data,
    output logic       error
);
    logic [2:0] syndrome;

    // code[k-1] holds codeword position k; the syndrome names the flipped position.
    assign syndrome[0] = code[0] ^ code[2] ^ code[4] ^ code[6];
    assign syndrome[1] = code[1] ^ code[2] ^ code[5] ^ code[6];
    assign syndrome[2] = code[3] ^ code[4] ^ code[5] ^ code[6];

    assign data[3] = code[2] ^ (syndrome == 3'd3);
    assign data[2] = code[4] ^ (syndrome == 3'd5);
    assign data[1] = code[5] ^ (syndrome == 3'd6);
    assign data[0] = code[6] ^ (syndrome == 3'd7);
    assign error   = |syndrome;
endmodule

module hamming_rx_ctrl #(
    parameter int ERR_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             bit_in,
    input  logic             bit_valid,
    output logic             bit_ready,
    output logic [7:0]       byte_out,
    output logic             byte_valid,
    input  logic             byte_ready,
    output logic             byte_err,
    input  logic             err_clr,
    output logic [ERR_W-1:0] err_count
);
    typedef enum logic [1:0] {
        ST_RECV,
        ST_DECODE,
        ST_WAIT
    } state_t;

    state_t           state_q, state_d;
    logic [2:0]       cnt_q, cnt_d;
    logic [6:0]       cw_q, cw_d;
    logic             sel_hi_q, sel_hi_d;
    logic [3:0]       low_nib_q, low_nib_d;
    logic             pend_err_q, pend_err_d;
    logic [7:0]       hold_byte_q, hold_byte_d;
    logic             hold_err_q, hold_err_d;
    logic [7:0]       byte_out_q, byte_out_d;
    logic             byte_valid_q, byte_valid_d;
    logic             byte_err_q, byte_err_d;
    logic             bit_ready_q, bit_ready_d;
    logic [ERR_W-1:0] err_count_q, err_count_d;

    logic [3:0]       dec_data;
    logic             dec_err;
    logic             bit_acc;
    logic             out_take;

    hamming_7_4 u_dec (
        .code  (cw_q),
        .data  (dec_data),
        .error (dec_err)
    );

    assign bit_acc  = bit_valid && bit_ready_q;
    assign out_take = byte_valid_q && byte_ready;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        cw_d         = cw_q;
        sel_hi_d     = sel_hi_q;
        low_nib_d    = low_nib_q;
        pend_err_d   = pend_err_q;
        hold_byte_d  = hold_byte_q;
        hold_err_d   = hold_err_q;
        byte_out_d   = byte_out_q;
        byte_err_d   = byte_err_q;
        byte_valid_d = byte_valid_q && !out_take;
        err_count_d  = err_count_q;

        case (state_q)
            ST_RECV: begin
                if (bit_acc) begin
                    // First bit received ends up in cw_q[0] (position 1).
                    cw_d = {bit_in, cw_q[6:1]};
                    if (cnt_q == 3'd6) begin
                        cnt_d   = 3'd0;
                        state_d = ST_DECODE;
                    end else begin
                        cnt_d = cnt_q + 3'd1;
                    end
                end
            end
            ST_DECODE: begin
                state_d = ST_RECV;
                if (!sel_hi_q) begin
                    low_nib_d  = dec_data;
                    pend_err_d = dec_err;
                    sel_hi_d   = 1'b1;
                end else begin
                    sel_hi_d = 1'b0;
                    if (!byte_valid_q || out_take) begin
                        byte_out_d   = {dec_data, low_nib_q};
                        byte_err_d   = dec_err | pend_err_q;
                        byte_valid_d = 1'b1;
                    end else begin
                        hold_byte_d = {dec_data, low_nib_q};
                        hold_err_d  = dec_err | pend_err_q;
                        state_d     = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (out_take) begin
                    byte_out_d   = hold_byte_q;
                    byte_err_d   = hold_err_q;
                    byte_valid_d = 1'b1;
                    state_d      = ST_RECV;
                end
            end
            default: state_d = ST_RECV;
        endcase

        if (err_clr) begin
            err_count_d = '0;
        end else if (state_q == ST_DECODE && dec_err && err_count_q != {ERR_W{1'b1}}) begin
            err_count_d = err_count_q + ERR_W'(1);
        end

        bit_ready_d = (state_d == ST_RECV);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_RECV;
            cnt_q        <= 3'd0;
            cw_q         <= 7'd0;
            sel_hi_q     <= 1'b0;
            low_nib_q    <= 4'd0;
            pend_err_q   <= 1'b0;
            hold_byte_q  <= 8'd0;
            hold_err_q   <= 1'b0;
            byte_out_q   <= 8'd0;
            byte_valid_q <= 1'b0;
            byte_err_q   <= 1'b0;
            bit_ready_q  <= 1'b1;
            err_count_q  <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            cw_q         <= cw_d;
            sel_hi_q     <= sel_hi_d;
            low_nib_q    <= low_nib_d;
            pend_err_q   <= pend_err_d;
            hold_byte_q  <= hold_byte_d;
            hold_err_q   <= hold_err_d;
            byte_out_q   <= byte_out_d;
            byte_valid_q <= byte_valid_d;
            byte_err_q   <= byte_err_d;
            bit_ready_q  <= bit_ready_d;
            err_count_q  <= err_count_d;
        end
    end

    assign bit_ready  = bit_ready_q;
    assign byte_out   = byte_out_q;
    assign byte_valid = byte_valid_q;
    assign byte_err   = byte_err_q;
    assign err_count  = err_count_q;
endmodule

// File: tb/tb_hamming_rx_ctrl.sv
// Bench for hamming_rx_ctrl: directed scenarios plus randomized traffic against
// a syndrome-based reference model; a second instance with a 2-bit counter checks saturation.

module tb_hamming_rx_ctrl;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst = 1'b1, bit_in = 1'b0, bit_valid = 1'b0, byte_ready = 1'b0, err_clr = 1'b0;
    logic       bit_ready, byte_valid, byte_err;
    logic [7:0] byte_out, err_count;
    logic       s_bit_ready, s_byte_valid, s_byte_err;
    logic [7:0] s_byte_out;
    logic [1:0] s_err_count;

    hamming_rx_ctrl #(.ERR_W(8)) u_dut (
        .clk(clk), .rst(rst), .bit_in(bit_in), .bit_valid(bit_valid), .bit_ready(bit_ready),
        .byte_out(byte_out), .byte_valid(byte_valid), .byte_ready(byte_ready),
        .byte_err(byte_err), .err_clr(err_clr), .err_count(err_count)
    );

    hamming_rx_ctrl #(.ERR_W(2)) u_sat (
        .clk(clk), .rst(rst), .bit_in(bit_in), .bit_valid(bit_valid), .bit_ready(s_bit_ready),
        .byte_out(s_byte_out), .byte_valid(s_byte_valid), .byte_ready(byte_ready),
        .byte_err(s_byte_err), .err_clr(err_clr), .err_count(s_err_count)
    );

    int checks = 0;
    int failures = 0;

    logic [8:0] exp_q[$];
    logic [8:0] rcv_q[$];

    // Reference model state
    int         m_nbits = 0;
    logic [6:0] m_cw = '0;
    bit         m_have_low = 0;
    logic [3:0] m_low = '0;
    bit         m_low_err = 0;
    int         m_err8 = 0, m_err2 = 0;
    bit         m_inc_pend = 0;
    bit         rdy_rand = 0;
    bit         prev_hold = 0;
    logic [8:0] prev_out = '0;
    int         stab_viol = 0;

    // Syndrome = XOR of the positions of all set bits; returns {error, nibble}.
    function automatic logic [4:0] model_decode(input logic [6:0] cw);
        int syn;
        logic [6:0] c;
        syn = 0;
        c = cw;
        for (int p = 1; p <= 7; p++) if (cw[p-1]) syn ^= p;
        if (syn != 0) c[syn-1] = ~c[syn-1];
        return {syn != 0, c[2], c[4], c[5], c[6]};
    endfunction

    // Data at positions 3,5,6,7; parity bits 1,2,4 chosen so the syndrome is 0.
    function automatic logic [6:0] encode(input logic [3:0] n, input int flip);
        logic [6:0] c;
        int s;
        c = '0;
        c[2] = n[3]; c[4] = n[2]; c[5] = n[1]; c[6] = n[0];
        s = 0;
        for (int p = 1; p <= 7; p++) if (c[p-1]) s ^= p;
        c[0] = s[0]; c[1] = s[1]; c[3] = s[2];
        if (flip != 0) c[flip-1] = ~c[flip-1];
        return c;
    endfunction

    task automatic tick(output bit acc);
        logic [4:0] d;
        if (rdy_rand) byte_ready = 1'($urandom_range(0, 1));
        acc = bit_valid && bit_ready;
        if (byte_valid === 1'b1 && byte_ready) rcv_q.push_back({byte_err, byte_out});
        if (prev_hold && (byte_valid !== 1'b1 || {byte_err, byte_out} !== prev_out)) stab_viol++;
        prev_hold = (byte_valid === 1'b1) && !byte_ready;
        prev_out  = {byte_err, byte_out};
        if (err_clr) begin
            m_err8 = 0; m_err2 = 0;
        end else if (m_inc_pend) begin
            if (m_err8 < 255) m_err8++;
            if (m_err2 < 3) m_err2++;
        end
        m_inc_pend = 0;
        if (rst) begin
            m_nbits = 0; m_have_low = 0; m_err8 = 0; m_err2 = 0;
            prev_hold = 0; exp_q.delete();
        end else if (acc) begin
            m_cw[m_nbits] = bit_in;
            m_nbits++;
            if (m_nbits == 7) begin
                m_nbits = 0;
                d = model_decode(m_cw);
                m_inc_pend = d[4];
                if (!m_have_low) begin
                    m_low = d[3:0]; m_low_err = d[4]; m_have_low = 1;
                end else begin
                    exp_q.push_back({d[4] | m_low_err, d[3:0], m_low});
                    m_have_low = 0;
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        bit acc;
        bit_valid = 1'b0;
        for (int i = 0; i < n; i++) tick(acc);
    endtask

    task automatic send_bit(input logic b);
        bit acc;
        int n;
        n = 0;
        bit_valid = 1'b1;
        bit_in = b;
        do begin
            tick(acc);
            n++;
        end while (!acc && n < 100);
        checks++;
        if (!acc) begin
            failures++;
            $display("FAIL send_bit_timeout: bit not accepted within %0d cycles, required acceptance", n);
        end
        bit_valid = 1'b0;
    endtask

    task automatic send_cw(input logic [3:0] n, input int flip);
        logic [6:0] c;
        c = encode(n, flip);
        for (int k = 0; k < 7; k++) send_bit(c[k]);
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        byte_ready = 1'b1;
        while (rcv_q.size() < exp_q.size() && n < 200) begin
            idle(1);
            n++;
        end
        idle(2);
    endtask

    task automatic do_reset();
        bit acc;
        rst = 1'b1; err_clr = 1'b0; bit_valid = 1'b0;
        tick(acc);
        rst = 1'b0;
        rcv_q.delete();
        exp_q.delete();
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({bit_ready, byte_valid, byte_err, byte_out, err_count} !== {1'b1, 1'b0, 1'b0, 8'h00, 8'h00}) begin
            failures++;
            $display("FAIL reset_state: ready=%b valid=%b err=%b out=%h cnt=%0d, required 1 0 0 00 0",
                     bit_ready, byte_valid, byte_err, byte_out, err_count);
        end
        checks++;
        if ({s_bit_ready, s_byte_valid, s_byte_err, s_byte_out, s_err_count} !== {1'b1, 1'b0, 1'b0, 8'h00, 2'd0}) begin
            failures++;
            $display("FAIL reset_state_sat: ready=%b valid=%b err=%b out=%h cnt=%0d, required 1 0 0 00 0",
                     s_bit_ready, s_byte_valid, s_byte_err, s_byte_out, s_err_count);
        end
    endtask

    task automatic test_clean_byte();
        bit acc;
        byte_ready = 1'b1;
        send_cw(4'hB, 0);
        send_cw(4'h0, 0);
        checks++;
        if (bit_ready !== 1'b0 || byte_valid !== 1'b0) begin
            failures++;
            $display("FAIL clean_decode_cycle: bit_ready=%b byte_valid=%b, required 0 0", bit_ready, byte_valid);
        end
        tick(acc);
        checks++;
        if ({byte_valid, byte_err, byte_out, bit_ready} !== {1'b1, 1'b0, 8'h0B, 1'b1}) begin
            failures++;
            $display("FAIL clean_byte_out: valid=%b err=%b out=%h bit_ready=%b, required 1 0 0b 1",
                     byte_valid, byte_err, byte_out, bit_ready);
        end
        tick(acc);
        checks++;
        if (byte_valid !== 1'b0) begin
            failures++;
            $display("FAIL clean_valid_drop: byte_valid=%b, required 0", byte_valid);
        end
        checks++;
        if (rcv_q.size() != 1 || rcv_q[0] !== 9'h00B || err_count !== 8'd0) begin
            failures++;
            $display("FAIL clean_result: nbytes=%0d first=%h cnt=%0d, required 1 00b 0",
                     rcv_q.size(), rcv_q.size() > 0 ? rcv_q[0] : 9'h1FF, err_count);
        end
    endtask

    task automatic test_correction();
        rcv_q.delete(); exp_q.delete();
        send_cw(4'hB, 5);
        send_cw(4'h0, 0);
        idle(3);
        checks++;
        if (rcv_q.size() != 1 || rcv_q[0] !== 9'h10B) begin
            failures++;
            $display("FAIL correction_byte: nbytes=%0d first=%h, required 1 10b",
                     rcv_q.size(), rcv_q.size() > 0 ? rcv_q[0] : 9'h1FF);
        end
        checks++;
        if (err_count !== 8'd1 || s_err_count !== 2'd1) begin
            failures++;
            $display("FAIL correction_count: cnt=%0d sat_cnt=%0d, required 1 1", err_count, s_err_count);
        end
    endtask

    task automatic test_back_to_back();
        bit acc;
        int bad;
        rcv_q.delete(); exp_q.delete();
        byte_ready = 1'b0;
        send_cw(4'hB, 0);
        send_cw(4'h0, 0);
        send_cw(4'h0, 0);
        send_cw(4'h0, 0);
        bad = 0;
        for (int i = 0; i < 6; i++) begin
            tick(acc);
            if (bit_ready !== 1'b0 || byte_valid !== 1'b1 || byte_out !== 8'h0B) bad++;
        end
        checks++;
        if (bad != 0 || stab_viol != 0) begin
            failures++;
            $display("FAIL backpressure_hold: bad_cycles=%0d stab_viol=%0d out=%h ready=%b, required 0 0 0b 0",
                     bad, stab_viol, byte_out, bit_ready);
        end
        byte_ready = 1'b1;
        tick(acc);
        checks++;
        if ({byte_valid, byte_out, bit_ready} !== {1'b1, 8'h00, 1'b1}) begin
            failures++;
            $display("FAIL backpressure_release: valid=%b out=%h bit_ready=%b, required 1 00 1",
                     byte_valid, byte_out, bit_ready);
        end
        tick(acc);
        checks++;
        if (rcv_q.size() != 2 || rcv_q[0] !== 9'h00B || rcv_q[1] !== 9'h000 || byte_valid !== 1'b0) begin
            failures++;
            $display("FAIL backpressure_order: nbytes=%0d valid=%b, required 2 bytes 00b,000 then valid 0",
                     rcv_q.size(), byte_valid);
        end
    endtask

    task automatic test_saturation();
        bit acc;
        do_reset();
        byte_ready = 1'b1;
        for (int i = 0; i < 4; i++) send_cw(4'($urandom), $urandom_range(1, 7));
        idle(3);
        checks++;
        if (err_count !== 8'(m_err8) || s_err_count !== 2'(m_err2) || m_err2 != 3 || m_err8 != 4) begin
            failures++;
            $display("FAIL saturation_count: cnt=%0d sat_cnt=%0d, required 4 3", err_count, s_err_count);
        end
        send_cw(4'($urandom), $urandom_range(1, 7));
        err_clr = 1'b1;
        tick(acc);
        err_clr = 1'b0;
        checks++;
        if (err_count !== 8'd0 || s_err_count !== 2'd0) begin
            failures++;
            $display("FAIL clear_priority: cnt=%0d sat_cnt=%0d, required 0 0", err_count, s_err_count);
        end
    endtask

    task automatic test_reset_mid();
        bit acc;
        logic [6:0] c;
        do_reset();
        byte_ready = 1'b1;
        send_cw(4'h5, 3);
        c = encode(4'h9, 0);
        for (int k = 0; k < 3; k++) send_bit(c[k]);
        rst = 1'b1;
        tick(acc);
        rst = 1'b0;
        rcv_q.delete();
        send_cw(4'hB, 0);
        send_cw(4'h0, 0);
        idle(4);
        checks++;
        if (rcv_q.size() != 1 || rcv_q[0] !== 9'h00B || err_count !== 8'd0) begin
            failures++;
            $display("FAIL reset_mid: nbytes=%0d first=%h cnt=%0d, required 1 00b 0",
                     rcv_q.size(), rcv_q.size() > 0 ? rcv_q[0] : 9'h1FF, err_count);
        end
    endtask

    task automatic test_gapped();
        bit acc;
        int bad;
        logic [13:0] bits;
        rcv_q.delete(); exp_q.delete();
        byte_ready = 1'b1;
        bits = {encode(4'h0, 0), encode(4'hB, 0)};
        bad = 0;
        for (int k = 0; k < 14; k++) begin
            send_bit(bits[k]);
            if (bit_ready !== ((k % 7 == 6) ? 1'b0 : 1'b1)) bad++;
            for (int g = 0; g < 3; g++) begin
                tick(acc);
                if (bit_ready !== 1'b1) bad++;
            end
        end
        idle(2);
        checks++;
        if (bad != 0 || rcv_q.size() != 1 || rcv_q[0] !== 9'h00B) begin
            failures++;
            $display("FAIL gapped: bad_ready_cycles=%0d nbytes=%0d first=%h, required 0 1 00b",
                     bad, rcv_q.size(), rcv_q.size() > 0 ? rcv_q[0] : 9'h1FF);
        end
    endtask

    task automatic test_random();
        int bad;
        rcv_q.delete(); exp_q.delete();
        stab_viol = 0;
        rdy_rand = 1;
        for (int i = 0; i < 40; i++) begin
            logic [6:0] c;
            c = encode(4'($urandom), ($urandom_range(0, 1) == 1) ? $urandom_range(1, 7) : 0);
            for (int k = 0; k < 7; k++) begin
                send_bit(c[k]);
                idle($urandom_range(0, 2));
            end
        end
        rdy_rand = 0;
        wait_drain();
        checks++;
        if (rcv_q.size() != exp_q.size() || exp_q.size() != 20) begin
            failures++;
            $display("FAIL random_count: got %0d bytes, required %0d (model) of 20", rcv_q.size(), exp_q.size());
        end
        bad = 0;
        for (int i = 0; i < rcv_q.size() && i < exp_q.size(); i++) begin
            checks++;
            if (rcv_q[i] !== exp_q[i]) begin
                failures++;
                $display("FAIL random_byte[%0d]: got %h, required %h", i, rcv_q[i], exp_q[i]);
            end
        end
        checks++;
        if (stab_viol != 0) begin
            failures++;
            $display("FAIL random_stability: %0d output changes under backpressure, required 0", stab_viol);
        end
        checks++;
        if (err_count !== 8'(m_err8) || s_err_count !== 2'(m_err2)) begin
            failures++;
            $display("FAIL random_err_count: cnt=%0d sat_cnt=%0d, required %0d %0d",
                     err_count, s_err_count, m_err8, m_err2);
        end
    endtask

    initial begin
        test_reset();
        test_clean_byte();
        test_correction();
        test_back_to_back();
        test_saturation();
        test_reset_mid();
        test_gapped();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
